bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Sequential owner of the shared 8-bit CPU bus source select. It arbitrates up to 8 bus-driver requests round-robin and inserts a one-cycle turnaround between owners. It drives `bus_sel`/`bus_en` into the 3-to-8 output-enable decoder and also presents an equivalent active-low one-hot grant vector. It sits in `src/control` between the control logic and the bus drivers, and guarantees that no two drivers ever see their enable in the same cycle.

## Interface
Parameters:
- `NUM_REQ`, default 8: number of requesters (2..8). `req` bits at index ≥ NUM_REQ are masked to 0.
- `HOLD_MAX`, default 15: maximum OWN cycles before forced release when another requester waits. Range 1..255. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 8: level request per driver. Held high for as long as the driver wants the bus.
- `bus_sel`, output, 3: index of the current owner; feeds decoder select `{a,b,c}`.
- `bus_en`, output, 1: high while a grant is valid; feeds decoder `g1`.
- `gnt_n`, output, 8: active-low one-hot grant. Equals `~(bus_en << bus_sel)`.
- `busy`, output, 1: high in OWN and TURN.
- `preempt`, output, 1: one-cycle pulse when the owner is forcibly released by timeout.

## Operation
- All outputs are registered. Reset values:
  - `bus_sel` = 0
  - `bus_en` = 0
  - `gnt_n` = 8'hFF
  - `busy` = 0
  - `preempt` = 0
  - internal `last` = NUM_REQ-1, so requester 0 wins first
  - hold counter = 0
  - state = IDLE
- States: IDLE, OWN, TURN.
- IDLE:
  - With masked `req` nonzero, the winner is the first set bit searching from `last+1` upward, wrapping modulo NUM_REQ.
  - Next state is OWN: `bus_sel` = winner, `bus_en` = 1, counter cleared.
  - With no request, remain in IDLE.
- OWN:
  - If `req[bus_sel]` = 0: go to TURN with `bus_en` = 0 and `last` = `bus_sel`.
  - Otherwise, if the timeout fires (counter == HOLD_MAX and another masked request is pending): go to TURN, set `last` = `bus_sel`, pulse `preempt`.
  - Otherwise remain in OWN; the counter increments and saturates at HOLD_MAX.
- TURN:
  - Exactly one cycle with `bus_en` = 0; `bus_sel` keeps the previous owner.
  - Arbitration is then identical to IDLE: go to OWN if any request is present, else IDLE.
- Round-robin: the previous owner has the lowest priority in the next arbitration, so it can re-win only when nobody else requests.
- Simultaneous owner drop and timeout in the same cycle: treated as a normal release, `preempt` stays 0.
- A preempted owner still holding `req` re-enters arbitration at lowest priority.
- `rst` asserted in any state forces all reset values at the next edge. There is no partial-grant state.

## Timing
- Grant latency from IDLE: `req` sampled high at edge k → `bus_en`/`gnt_n` valid after edge k (one cycle).
- Release: `req[owner]` sampled low at edge k → `bus_en` = 0 after edge k. The next owner is granted after edge k+1.
- Minimum gap between two different owners: exactly 1 cycle with `bus_en` = 0.
- With `ARB_TIMEOUT_EN`, a continuously contested owner holds the bus for HOLD_MAX+1 cycles, then TURN.
- `preempt` is high in the same cycle as the TURN it caused.
- `gnt_n` always has at most one zero bit. It is never zero for an index ≥ NUM_REQ.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter and forced release are built.
  - `preempt` is functional.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and HOLD_MAX is ignored.
  - The owner keeps the bus until it drops `req`.
  - `preempt` is tied 0.

## Test plan
- Reset with `req` = 8'h00 → `gnt_n` = 8'hFF, `bus_en` = 0, `busy` = 0. Then `req` = 8'h01 → `bus_sel` = 0, `gnt_n` = 8'hFE one cycle later.
- `req` = 8'h09 held, each owner drops `req` after 2 cycles of ownership and re-raises 1 cycle later:
  - Grants alternate 0, 3, 0, 3.
  - Each handover shows exactly one cycle with `bus_en` = 0.
- `req` = 8'h80 with `NUM_REQ` = 4 → no grant, `gnt_n` stays 8'hFF.
- `ARB_TIMEOUT_EN`, `HOLD_MAX` = 3:
  - Owner 1 holds, and `req[5]` rises while owner 1 is in its 2nd OWN cycle.
  - Owner 1 is released after 4 OWN cycles with `preempt` = 1 for 1 cycle.
  - Owner 5 is granted next.
- Owner 2 drops `req` in the same cycle its timeout fires → TURN with `preempt` = 0.
- `rst` pulsed for one cycle while owner 6 holds → next cycle `gnt_n` = 8'hFF, `bus_sel` = 0. With all requests held after reset, requester 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin owner of the shared 8-bit CPU bus source select. It grants one
// of up to NUM_REQ level requesters and drives the 3-to-8 output-enable
// decoder (bus_sel -> {a,b,c}, bus_en -> g1). Between two owners there is
// always exactly one TURN cycle with bus_en low, so two drivers can never
// see their enable in the same cycle.
//
// Parameters:
//   NUM_REQ  - number of requesters (2..8); req bits at index >= NUM_REQ
//              are ignored
//   HOLD_MAX - OWN cycles (counted from 0) after which a contested owner is
//              forcibly released (1..255); only used with ARB_TIMEOUT_EN
//
// Optional feature macro:
//   ARB_TIMEOUT_EN - builds the hold counter and the forced release. When it
//                    is undefined an owner keeps the bus until it drops req
//                    and preempt stays 0.
//
// Ports:
//   clk     in   system clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset
//   req     in   [7:0] level request per bus driver
//   bus_sel out  [2:0] index of the current / most recent owner
//   bus_en  out  grant valid
//   gnt_n   out  [7:0] active-low one-hot grant, ~(bus_en << bus_sel)
//   busy    out  high in OWN and TURN
//   preempt out  one-cycle pulse in the TURN caused by a timeout
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] bus_sel,
    output logic       bus_en,
    output logic [7:0] gnt_n,
    output logic       busy,
    output logic       preempt
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_param
        $error("bus_arbiter: NUM_REQ or HOLD_MAX out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [7:0] REQ_MASK = 8'((9'h1 << NUM_REQ) - 9'h1);
    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

    // Round-robin search: first set bit starting at last+1, wrapping modulo
    // NUM_REQ. The loop runs from the far end back towards last+1 so the
    // closest candidate is the one written last. Result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] mreq_in,
                                           input logic [2:0] last_in);
        logic [3:0] res;
        int         idx;
        res = 4'h0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_in) + i) % NUM_REQ;
            if (mreq_in[3'(idx)]) begin
                res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [2:0] sel_nxt;
    logic       en_nxt;
    logic [7:0] gnt_nxt;
    logic       busy_nxt;
    logic       pre_nxt;
    logic [7:0] mreq;
    logic [3:0] pick;
    logic       owner_req;
    logic       timeout;

    assign mreq      = req & REQ_MASK;
    assign pick      = rr_pick(mreq, last);
    assign owner_req = mreq[bus_sel];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic [7:0] cnt, cnt_nxt;
    logic [7:0] owner_oh;

    assign owner_oh = 8'h01 << bus_sel;
    // Forced release only when somebody else is actually waiting.
    assign timeout  = (cnt == HOLD_LIM) && ((mreq & ~owner_oh) != 8'h00);

    // Counter clears on every new grant and saturates at HOLD_LIM while
    // the owner keeps the bus.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt == OWN && state != OWN) begin
            cnt_nxt = 8'h00;
        end else if (state == OWN && cnt != HOLD_LIM) begin
            cnt_nxt = cnt + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'h00;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = bus_sel;
        en_nxt    = 1'b0;
        pre_nxt   = 1'b0;
        last_nxt  = last;
        case (state)
            IDLE, TURN: begin
                if (pick[3]) begin
                    state_nxt = OWN;
                    sel_nxt   = pick[2:0];
                    en_nxt    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN: begin
                // A voluntary drop wins over a simultaneous timeout, so
                // preempt only marks genuinely forced releases.
                if (!owner_req) begin
                    state_nxt = TURN;
                    last_nxt  = bus_sel;
                end else if (timeout) begin
                    state_nxt = TURN;
                    last_nxt  = bus_sel;
                    pre_nxt   = 1'b1;
                end else begin
                    en_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        gnt_nxt  = en_nxt ? ~(8'h01 << sel_nxt) : 8'hFF;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bus_sel <= 3'd0;
            bus_en  <= 1'b0;
            gnt_n   <= 8'hFF;
            busy    <= 1'b0;
            preempt <= 1'b0;
            last    <= LAST_RST;
        end else begin
            state   <= state_nxt;
            bus_sel <= sel_nxt;
            bus_en  <= en_nxt;
            gnt_n   <= gnt_nxt;
            busy    <= busy_nxt;
            preempt <= pre_nxt;
            last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Two arbiters (NUM_REQ=8/HOLD_MAX=3 and NUM_REQ=4/HOLD_MAX=5) share one req
// bus. A cycle-level reference model, written in terms of "who owns the bus
// and for how long", predicts every output of both instances each cycle;
// directed scenarios add explicit expectations on top.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;

    logic [2:0] sel8, sel4;
    logic       en8, en4;
    logic [7:0] gnt8, gnt4;
    logic       busy8, busy4;
    logic       pre8, pre4;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_REQ(8), .HOLD_MAX(3)) u8 (
        .clk(clk), .rst(rst), .req(req),
        .bus_sel(sel8), .bus_en(en8), .gnt_n(gnt8), .busy(busy8), .preempt(pre8)
    );

    bus_arbiter #(.NUM_REQ(4), .HOLD_MAX(5)) u4 (
        .clk(clk), .rst(rst), .req(req),
        .bus_sel(sel4), .bus_en(en4), .gnt_n(gnt4), .busy(busy4), .preempt(pre4)
    );

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owner (-1 when nobody owns), whether we are in the
    // one-cycle gap after a release, the displayed index, the last owner
    // and how many cycles the current owner has held beyond its first.
    typedef struct {
        int own;
        bit gap;
        int sel;
        int last;
        int held;
        bit pre;
    } model_t;

    model_t m8, m4;

    function automatic model_t model_next(input model_t s, input int n, input int hold,
                                          input logic [7:0] r, input logic rs);
        model_t t;
        int     m;
        int     others;
        t = s;
        if (rs) begin
            t.own = -1; t.gap = 1'b0; t.sel = 0; t.last = n - 1; t.held = 0; t.pre = 1'b0;
            return t;
        end
        m     = int'(r) & ((1 << n) - 1);
        t.pre = 1'b0;
        if (s.own >= 0) begin
            others = m & ~(1 << s.own);
            if (((m >> s.own) & 1) == 0) begin
                t.own = -1; t.gap = 1'b1; t.last = s.own;
            end else if (TO_EN && s.held == hold && others != 0) begin
                t.own = -1; t.gap = 1'b1; t.last = s.own; t.pre = 1'b1;
            end else begin
                t.held = (s.held < hold) ? s.held + 1 : hold;
            end
        end else begin
            t.gap = 1'b0;
            for (int i = 1; i <= n; i++) begin
                int c;
                c = (s.last + i) % n;
                if (t.own < 0 && ((m >> c) & 1) != 0) begin
                    t.own = c; t.sel = c; t.held = 0;
                end
            end
        end
        return t;
    endfunction

    function automatic logic [13:0] model_out(input model_t s);
        logic [7:0] g;
        logic       en;
        en = (s.own >= 0);
        g  = en ? ~(8'h01 << s.own) : 8'hFF;
        return {3'(s.sel), en, g, en || s.gap, s.pre};
    endfunction

    always @(posedge clk) begin
        m8 <= model_next(m8, 8, 3, req, rst);
        m4 <= model_next(m4, 4, 5, req, rst);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_u8", 32'({sel8, en8, gnt8, busy8, pre8}), 32'(model_out(m8)));
            check("model_u4", 32'({sel4, en4, gnt4, busy4, pre4}), 32'(model_out(m4)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int g[$];
        int exp_g[4];
        int dropped;
        int oc;
        int zeros;
        int own_cnt;

        // Reset state and first grant
        rst = 1'b1;
        req = 8'h00;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_gnt_n", 32'(gnt8), 32'hFF);
        check("rst_bus_en", 32'(en8), 32'h0);
        check("rst_busy", 32'(busy8), 32'h0);
        rst = 1'b0;
        req = 8'h01;
        tick();
        check("first_sel", 32'(sel8), 32'h0);
        check("first_gnt_n", 32'(gnt8), 32'hFE);

        // Alternating owners 0 and 3 with one-cycle handover gaps
        req = 8'h00;
        do_reset();
        req     = 8'h09;
        dropped = -1;
        oc      = 0;
        zeros   = 0;
        for (int k = 0; k < 40 && g.size() < 4; k++) begin
            tick();
            if (dropped >= 0) begin
                req[3'(dropped)] = 1'b1;
                dropped = -1;
            end
            if (en8) begin
                if (oc == 0) begin
                    g.push_back(int'(sel8));
                    if (g.size() > 1) check("handover_gap", 32'(zeros), 32'd1);
                end
                zeros = 0;
                oc++;
                if (oc == 2) begin
                    req[sel8] = 1'b0;
                    dropped   = int'(sel8);
                    oc        = 0;
                end
            end else begin
                zeros++;
            end
        end
        exp_g = '{0, 3, 0, 3};
        check("grant_count", 32'(g.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < g.size()) check("grant_order", 32'(g[i]), 32'(exp_g[i]));
        end

        // Request above NUM_REQ is ignored by the 4-requester instance
        req = 8'h80;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mask_gnt_n", 32'(gnt4), 32'hFF);
            check("mask_bus_en", 32'(en4), 32'h0);
        end

`ifdef ARB_TIMEOUT_EN
        // Contested owner 1 is forced out after HOLD_MAX+1 = 4 cycles
        req = 8'h00;
        do_reset();
        req = 8'h02;
        tick();
        check("to_first_sel", 32'({en8, sel8}), 32'({1'b1, 3'd1}));
        tick();
        req[5]  = 1'b1;
        own_cnt = 2;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (en8 && sel8 == 3'd1) own_cnt++;
            else break;
        end
        check("to_own_cycles", 32'(own_cnt), 32'd4);
        check("to_preempt", 32'(pre8), 32'h1);
        check("to_turn_en", 32'(en8), 32'h0);
        tick();
        check("to_preempt_pulse", 32'(pre8), 32'h0);
        check("to_next_owner", 32'({en8, sel8}), 32'({1'b1, 3'd5}));
`endif

        // Owner 2 drops req in the cycle its timeout would fire
        req = 8'h00;
        do_reset();
        req = 8'h04;
        tick();
        req[6] = 1'b1;
        tick();
        tick();
        tick();
        check("drop_owner", 32'({en8, sel8}), 32'({1'b1, 3'd2}));
        req[2] = 1'b0;
        tick();
        check("drop_turn", 32'({en8, busy8, pre8}), 32'b010);
        tick();
        check("drop_next", 32'({en8, sel8}), 32'({1'b1, 3'd6}));

        // Reset while owner 6 holds; all requesters then compete
        req = 8'h00;
        do_reset();
        req = 8'h40;
        tick();
        check("rst6_owner", 32'({en8, sel8}), 32'({1'b1, 3'd6}));
        rst = 1'b1;
        req = 8'hFF;
        tick();
        check("rst6_gnt_n", 32'(gnt8), 32'hFF);
        check("rst6_sel", 32'(sel8), 32'h0);
        rst = 1'b0;
        tick();
        check("rst6_regrant", 32'({sel8, gnt8}), 32'({3'd0, 8'hFE}));

        // Randomized traffic with occasional resets
        req = 8'h00;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
